// File: rtl/run_detector.sv
// run_detector: parametrised Moore detector for RUN_LEN consecutive qualified ones on w.
// Optional hit counter / sticky overflow flag built only when RUN_DETECTOR_HITCNT_EN is
// defined; otherwise hit_cnt and hit_ovf are tied to zero.
module run_detector #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned RunW   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic [RunW-1:0]  run_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             hit_ovf
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHit  = 2'd2
  } state_e;

  localparam logic [RunW-1:0] RunMax  = RunW'(RUN_LEN);
  localparam logic [RunW-1:0] RunLast = RunW'(RUN_LEN - 1);
  localparam logic [RunW-1:0] RunOne  = RunW'(1);

  state_e          state_q;
  logic [RunW-1:0] run_q;
  logic            z_q;

  // FSM: state, run length and registered z (z_q mirrors state_q == StHit)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      run_q   <= '0;
      z_q     <= 1'b0;
    end else if (clr) begin
      state_q <= StIdle;
      run_q   <= '0;
      z_q     <= 1'b0;
    end else if (!en) begin
      // Hold, but still recover from an illegal encoding
      if (state_q != StIdle && state_q != StRun && state_q != StHit) begin
        state_q <= StIdle;
        run_q   <= '0;
        z_q     <= 1'b0;
      end
    end else if (!w) begin
      state_q <= StIdle;
      run_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StRun;
          run_q   <= RunOne;
          z_q     <= 1'b0;
        end
        StRun: begin
          if (run_q == RunLast) begin
            state_q <= StHit;
            run_q   <= RunMax;
            z_q     <= 1'b1;
          end else begin
            run_q   <= run_q + RunOne;
            z_q     <= 1'b0;
          end
        end
        StHit: begin
          if (overlap) begin
            z_q <= 1'b1;
          end else begin
            // Current one starts a fresh run
            state_q <= StRun;
            run_q   <= RunOne;
            z_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          run_q   <= '0;
          z_q     <= 1'b0;
        end
      endcase
    end
  end

  assign z       = z_q;
  assign run_cnt = run_q;

`ifdef RUN_DETECTOR_HITCNT_EN
  logic             hit_evt;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             hit_ovf_q;

  // A hit is any qualified edge whose next state is HIT
  always_comb begin
    hit_evt = 1'b0;
    if (!clr && en && w) begin
      hit_evt = (state_q == StRun && run_q == RunLast) || (state_q == StHit && overlap);
    end
  end

  // Saturating hit counter with sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
      hit_ovf_q <= 1'b0;
    end else if (clr) begin
      hit_cnt_q <= '0;
      hit_ovf_q <= 1'b0;
    end else if (hit_evt) begin
      if (&hit_cnt_q) begin
        hit_ovf_q <= 1'b1;
      end else begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_cnt = hit_cnt_q;
  assign hit_ovf = hit_ovf_q;
`else
  assign hit_cnt = '0;
  assign hit_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: directed scenarios plus random stimulus compared
// against an integer-level model. Two instances (CNT_W = 8 and CNT_W = 2) share inputs.
module tb_run_detector;

  localparam int unsigned RunLen = 3;

`ifdef RUN_DETECTOR_HITCNT_EN
  localparam bit HitEn = 1'b1;
`else
  localparam bit HitEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       w;
  logic       overlap;
  logic       clr;
  logic       z_a, z_b;
  logic [1:0] run_a, run_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       ovf_a, ovf_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current run length (saturating at RunLen) and total hits since reset/clr
  int     m_run  = 0;
  longint m_hits = 0;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(RunLen), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .w(w), .overlap(overlap), .clr(clr),
    .z(z_a), .run_cnt(run_a), .hit_cnt(cnt_a), .hit_ovf(ovf_a)
  );

  run_detector #(.RUN_LEN(RunLen), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .w(w), .overlap(overlap), .clr(clr),
    .z(z_b), .run_cnt(run_b), .hit_cnt(cnt_b), .hit_ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int wd);
    longint sat;
    sat = (longint'(1) << wd) - 1;
    if (!HitEn) return 64'd0;
    return (m_hits > sat) ? 64'(sat) : 64'(m_hits);
  endfunction

  function automatic logic [63:0] exp_ovf(input int wd);
    longint sat;
    sat = (longint'(1) << wd) - 1;
    if (!HitEn) return 64'd0;
    return (m_hits > sat) ? 64'd1 : 64'd0;
  endfunction

  task automatic check_all();
    check("z_a", 64'(z_a), 64'(m_run == RunLen));
    check("run_a", 64'(run_a), 64'(m_run));
    check("cnt_a", 64'(cnt_a), exp_cnt(8));
    check("ovf_a", 64'(ovf_a), exp_ovf(8));
    check("z_b", 64'(z_b), 64'(m_run == RunLen));
    check("run_b", 64'(run_b), 64'(m_run));
    check("cnt_b", 64'(cnt_b), exp_cnt(2));
    check("ovf_b", 64'(ovf_b), exp_ovf(2));
  endtask

  task automatic model_step(input logic e, input logic ww, input logic ov, input logic c);
    if (c) begin
      m_run  = 0;
      m_hits = 0;
    end else if (e) begin
      if (!ww) begin
        m_run = 0;
      end else if (m_run == RunLen) begin
        if (ov) m_hits++;
        else m_run = 1;
      end else begin
        m_run++;
        if (m_run == RunLen) m_hits++;
      end
    end
  endtask

  // One clock: drive, model on the edge, check 1 time unit later
  task automatic step(input logic e, input logic ww, input logic ov, input logic c);
    en = e; w = ww; overlap = ov; clr = c;
    @(posedge clk);
    model_step(e, ww, ov, c);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge
  task automatic async_reset();
    rst = 1'b0;
    m_run  = 0;
    m_hits = 0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; w = 1'b0; overlap = 1'b0; clr = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-run with run_cnt = 2, then a fresh run of three
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("mid_run", 64'(run_a), 64'd2);
    async_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("post_rst_z", 64'(z_a), 64'd1);

    // Overlap: five ones then a zero
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
    check("ovl_hits", 64'(cnt_a), HitEn ? 64'd3 : 64'd0);
    step(1, 0, 1, 0);
    check("ovl_z_low", 64'(z_a), 64'd0);

    // Non-overlap: six ones, then 1,1,0,1,1,1
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    check("novl_hits", 64'(cnt_a), HitEn ? 64'd2 : 64'd0);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check("seq_hits", 64'(cnt_a), HitEn ? 64'd1 : 64'd0);

    // Enable bubbles, including an ignored w = 0 sample with en = 0
    step(0, 0, 0, 1);
    step(1, 1, 0, 0); step(0, 0, 0, 0); step(1, 1, 0, 0);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    check("bubble_run", 64'(run_a), 64'd3);
    check("bubble_z", 64'(z_a), 64'd1);

    // Saturation of the narrow counter, then clr beats en/w
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0);
    check("sat_cnt_b", 64'(cnt_b), HitEn ? 64'd3 : 64'd0);
    check("sat_ovf_b", 64'(ovf_b), HitEn ? 64'd1 : 64'd0);
    step(1, 1, 1, 1);
    check("clr_z", 64'(z_b), 64'd0);
    check("clr_ovf", 64'(ovf_b), 64'd0);

    // Saturate the 8-bit counter with a long overlap burst
    for (int i = 0; i < 260; i++) step(1, 1, 1, 0);
    check("sat_ovf_a", 64'(ovf_a), HitEn ? 64'd1 : 64'd0);
    step(0, 0, 0, 1);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 5) begin
        async_reset();
      end else begin
        step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) < 7),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
